// File: rtl/mem_rf_if.sv
// mem_rf_if: bundles the storage-array bus of mem_rf.
//   busy  : high while the post-reset clear sweep is running
//   wen   : write request
//   wmask : per-lane write enable, lane i = wdata[i*BYTE_SIZE +: BYTE_SIZE]
//   waddr : write address
//   wdata : write data
//   raddr : packed read addresses, port p = raddr[p*ADDR_SIZE +: ADDR_SIZE]
//   rdata : packed read data, port p = rdata[p*W +: W]
// The master modport is the datapath side; the slave modport is the memory.
interface mem_rf_if #(
  parameter int ADDR_SIZE      = 4,
  parameter int BYTE_SIZE      = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int NUM_READ       = 2
);
  localparam int W = BYTE_SIZE * BYTES_PER_WORD;

  logic                          busy;
  logic                          wen;
  logic [BYTES_PER_WORD-1:0]     wmask;
  logic [ADDR_SIZE-1:0]          waddr;
  logic [W-1:0]                  wdata;
  logic [NUM_READ*ADDR_SIZE-1:0] raddr;
  logic [NUM_READ*W-1:0]         rdata;

  modport master (
    input  busy, rdata,
    output wen, wmask, waddr, wdata, raddr
  );

  modport slave (
    output busy, rdata,
    input  wen, wmask, waddr, wdata, raddr
  );
endinterface

// File: rtl/mem_rf.sv
// mem_rf: multi-read-port, byte-maskable register-file memory.
// After every reset a sequencer zeroes all DEPTH words, one per cycle, and
// holds busy high meanwhile; writes are dropped and reads return 0 until the
// sweep completes. Reads are combinational (READ_LATENCY=0) or registered
// (READ_LATENCY=1), the latter optionally forwarding same-cycle write lanes.
// Ports:
//   clock : sole clock, all state changes on posedge
//   reset : synchronous, active-high
//   bus   : mem_rf_if slave (busy, wen, wmask, waddr, wdata, raddr, rdata)
module mem_rf #(
  parameter int ADDR_SIZE      = 4,
  parameter int BYTE_SIZE      = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int NUM_READ       = 2,
  parameter int READ_LATENCY   = 1,
  parameter int BYPASS         = 1
) (
  input  logic     clock,
  input  logic     reset,
  mem_rf_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam int W     = BYTE_SIZE * BYTES_PER_WORD;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = '1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [ADDR_SIZE-1:0]  r_clrAddr;
  logic [W-1:0]          r_mem [DEPTH];
  logic [NUM_READ*W-1:0] w_readData;

  // State register and clear-address counter. The counter only advances
  // while clearing; it is left parked in READY.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= CLEAR;
      r_clrAddr <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == CLEAR) begin
        r_clrAddr <= r_clrAddr + 1'b1;
      end
    end
  end

  // Leave CLEAR on the edge that zeroes the last word.
  always_comb begin
    w_nextState = r_state;
    if (r_state == CLEAR && r_clrAddr == LAST_ADDR) begin
      w_nextState = READY;
    end
  end

  assign bus.busy = (r_state == CLEAR);

  // Array update: the clear sweep owns the array while CLEAR, so any write
  // request then is simply lost. Reset edges leave the contents alone.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (r_state == CLEAR) begin
        r_mem[r_clrAddr] <= '0;
      end else if (bus.wen) begin
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
          if (bus.wmask[i]) begin
            r_mem[bus.waddr][i*BYTE_SIZE +: BYTE_SIZE] <= bus.wdata[i*BYTE_SIZE +: BYTE_SIZE];
          end
        end
      end
    end
  end

  // Raw array read per port, forced to zero while clearing so that
  // uninitialised contents never escape before the first sweep finishes.
  always_comb begin
    w_readData = '0;
    if (r_state == READY) begin
      for (int p = 0; p < NUM_READ; p++) begin
        w_readData[p*W +: W] = r_mem[bus.raddr[p*ADDR_SIZE +: ADDR_SIZE]];
      end
    end
  end

  generate
    if (READ_LATENCY == 0) begin : gCombRead
      assign bus.rdata = w_readData;
    end else begin : gRegRead
      logic [NUM_READ*W-1:0] w_nextData;
      logic [NUM_READ*W-1:0] r_rdata;

      // With bypass, a port reading the address being written sees the
      // written lanes merged over the old word, as the array will hold it
      // after this edge.
      always_comb begin
        w_nextData = w_readData;
        if (BYPASS != 0 && r_state == READY && bus.wen) begin
          for (int p = 0; p < NUM_READ; p++) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
              if (bus.raddr[p*ADDR_SIZE +: ADDR_SIZE] == bus.waddr && bus.wmask[i]) begin
                w_nextData[p*W + i*BYTE_SIZE +: BYTE_SIZE] = bus.wdata[i*BYTE_SIZE +: BYTE_SIZE];
              end
            end
          end
        end
      end

      // Read result register, cleared by reset.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_rdata <= '0;
        end else begin
          r_rdata <= w_nextData;
        end
      end

      assign bus.rdata = r_rdata;
    end
  endgenerate
endmodule

// File: tb/tb_mem_rf.sv
// tb_mem_rf: drives three mem_rf instances with identical stimulus:
//   dutA : registered read with bypass, 2 ports
//   dutB : registered read without bypass, 2 ports
//   dutC : combinational read, 3 ports
// A word-level array model predicts every output; predictions are queued at
// stimulus time and a monitor pops and compares them at each negedge.
module tb_mem_rf;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic            busy;
    logic [1:0][31:0] a;
    logic [1:0][31:0] b;
    logic [2:0][31:0] c;
  } exp_t;

  logic clock = 1'b0;
  logic rst;
  logic wen;
  logic [3:0] wmask;
  logic [3:0] waddr;
  logic [31:0] wdata;
  logic [2:0][3:0] raddr;

  exp_t expQ[$];
  int nChecks = 0;
  int nPass = 0;

  // model state
  logic [31:0] model [DEPTH];
  int clearLeft;
  logic [1:0][31:0] prevA;
  logic [1:0][31:0] prevB;

  mem_rf_if #(.NUM_READ(2)) ifA ();
  mem_rf_if #(.NUM_READ(2)) ifB ();
  mem_rf_if #(.NUM_READ(3)) ifC ();

  assign ifA.wen = wen;  assign ifA.wmask = wmask;  assign ifA.waddr = waddr;
  assign ifA.wdata = wdata;  assign ifA.raddr = raddr[1:0];
  assign ifB.wen = wen;  assign ifB.wmask = wmask;  assign ifB.waddr = waddr;
  assign ifB.wdata = wdata;  assign ifB.raddr = raddr[1:0];
  assign ifC.wen = wen;  assign ifC.wmask = wmask;  assign ifC.waddr = waddr;
  assign ifC.wdata = wdata;  assign ifC.raddr = raddr;

  mem_rf #(.NUM_READ(2), .READ_LATENCY(1), .BYPASS(1)) dutA (
    .clock(clock), .reset(rst), .bus(ifA));
  mem_rf #(.NUM_READ(2), .READ_LATENCY(1), .BYPASS(0)) dutB (
    .clock(clock), .reset(rst), .bus(ifB));
  mem_rf #(.NUM_READ(3), .READ_LATENCY(0), .BYPASS(0)) dutC (
    .clock(clock), .reset(rst), .bus(ifC));

  always #5 clock = ~clock;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after a posedge, queue the outputs the
  // model predicts for the following negedge, then advance the model across
  // the next posedge.
  task automatic applyStimulus(input logic r, input logic we, input logic [3:0] m,
                               input logic [3:0] wa, input logic [31:0] wd,
                               input logic [3:0] r0, input logic [3:0] r1,
                               input logic [3:0] r2);
    exp_t e;
    logic [3:0] ra [3];
    logic [31:0] oldWord;
    logic [31:0] merged;
    logic busyNow;
    @(posedge clock);
    #1;
    rst = r;  wen = we;  wmask = m;  waddr = wa;  wdata = wd;
    raddr = {r2, r1, r0};
    ra[0] = r0;  ra[1] = r1;  ra[2] = r2;
    busyNow = (clearLeft > 0);

    e.busy = busyNow;
    e.a = prevA;
    e.b = prevB;
    for (int p = 0; p < 3; p++) begin
      e.c[p] = busyNow ? 32'h0 : model[ra[p]];
    end
    expQ.push_back(e);

    for (int p = 0; p < 2; p++) begin
      oldWord = (r || busyNow) ? 32'h0 : model[ra[p]];
      merged = oldWord;
      if (!r && !busyNow && we && ra[p] == wa) begin
        for (int i = 0; i < 4; i++) begin
          if (m[i]) merged[i*8 +: 8] = wd[i*8 +: 8];
        end
      end
      prevA[p] = merged;
      prevB[p] = oldWord;
    end

    if (r) begin
      clearLeft = DEPTH;
    end else if (clearLeft > 0) begin
      model[DEPTH - clearLeft] = 32'h0;
      clearLeft--;
    end else if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (m[i]) model[wa][i*8 +: 8] = wd[i*8 +: 8];
      end
    end
  endtask

  task automatic idleRead(input logic r);
    applyStimulus(r, 1'b0, 4'h0, 4'h0, 32'h0, 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  task automatic sweepRead();
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 4'(a), 4'(a), 4'(DEPTH - 1 - a));
    end
    idleRead(1'b0);
  endtask

  // Monitor: compares every DUT output once per cycle at the negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("A.busy", 32'(ifA.busy), 32'(e.busy));
        checkOutput("B.busy", 32'(ifB.busy), 32'(e.busy));
        checkOutput("C.busy", 32'(ifC.busy), 32'(e.busy));
        for (int p = 0; p < 2; p++) begin
          checkOutput($sformatf("A.rdata%0d", p), ifA.rdata[p*32 +: 32], e.a[p]);
          checkOutput($sformatf("B.rdata%0d", p), ifB.rdata[p*32 +: 32], e.b[p]);
        end
        for (int p = 0; p < 3; p++) begin
          checkOutput($sformatf("C.rdata%0d", p), ifC.rdata[p*32 +: 32], e.c[p]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;  wen = 1'b0;  wmask = 4'h0;  waddr = 4'h0;  wdata = 32'h0;
    raddr = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    clearLeft = DEPTH;
    prevA = '0;
    prevB = '0;

    $display("[TB] reset and initial clear");
    idleRead(1'b1);
    idleRead(1'b1);
    for (int i = 0; i < 16; i++) idleRead(1'b0);
    sweepRead();

    $display("[TB] reset mid-clear, write while busy");
    idleRead(1'b1);
    for (int i = 0; i < 5; i++) idleRead(1'b0);
    idleRead(1'b1);
    applyStimulus(1'b0, 1'b1, 4'hF, 4'd3, 32'hFFFF_FFFF, 4'd3, 4'd3, 4'd3);
    for (int i = 0; i < 16; i++) idleRead(1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 4'd3, 4'd3, 4'd3);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 4'd3, 4'd3, 4'd3);

    $display("[TB] byte mask");
    applyStimulus(1'b0, 1'b1, 4'hF, 4'd7, 32'h1122_3344, 4'd7, 4'd7, 4'd7);
    applyStimulus(1'b0, 1'b1, 4'h5, 4'd7, 32'hAABB_CCDD, 4'd7, 4'd7, 4'd7);
    applyStimulus(1'b0, 1'b1, 4'h0, 4'd7, 32'h5555_5555, 4'd7, 4'd7, 4'd7);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 4'd7, 4'd7, 4'd7);
    idleRead(1'b0);

    $display("[TB] bypass");
    applyStimulus(1'b0, 1'b1, 4'hF, 4'd2, 32'h0102_0304, 4'd0, 4'd1, 4'd0);
    applyStimulus(1'b0, 1'b1, 4'h3, 4'd2, 32'hA0B0_C0D0, 4'd2, 4'd2, 4'd2);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 4'd2, 4'd2, 4'd2);
    idleRead(1'b0);

    $display("[TB] combinational three-port read");
    applyStimulus(1'b0, 1'b1, 4'hF, 4'd4, 32'hDEAD_BEEF, 4'd0, 4'd0, 4'd0);
    applyStimulus(1'b0, 1'b1, 4'hF, 4'd5, 32'h1234_5678, 4'd0, 4'd0, 4'd0);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 4'd4, 4'd5, 4'd4);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 4'd4, 4'd5, 4'd4);

    $display("[TB] fill then reset in ready, write with reset dropped");
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b0, 1'b1, 4'hF, 4'(a), 32'h0101_0101 * (a + 1), 4'(a), 4'(a), 4'(a));
    end
    applyStimulus(1'b1, 1'b1, 4'hF, 4'd0, 32'hCAFE_F00D, 4'd9, 4'd10, 4'd11);
    for (int i = 0; i < 17; i++) idleRead(1'b0);
    sweepRead();

    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0), 1'($urandom), 4'($urandom),
                    4'($urandom_range(0, 15)), $urandom,
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)));
    end

    @(negedge clock);
    #1;
    checkOutput("queueDrained", 32'(expQ.size()), 32'h0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
